// File: rtl/window_addr_gen.sv
// Window address generator: for each accepted window origin, streams the
// linear addresses of a SWEEP_X x SWEEP_Y window in row-major order. Each
// beat carries row_last and win_last markers.
module window_addr_gen #(
  parameter int IMG_WIDTH  = 41,
  parameter int IMG_HEIGHT = 50,
  parameter int SWEEP_X    = 24,
  parameter int SWEEP_Y    = 24,
  localparam int W_X = $clog2(IMG_WIDTH),
  localparam int W_Y = $clog2(IMG_HEIGHT),
  localparam int W_A = $clog2(IMG_WIDTH*IMG_HEIGHT)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           hop_valid,
  output logic           hop_ready,
  input  logic [W_X-1:0] x_hop,
  input  logic [W_Y-1:0] y_hop,
  output logic           addr_valid,
  input  logic           addr_ready,
  output logic [W_A-1:0] addr,
  output logic           row_last,
  output logic           win_last
);

  localparam int W_C = (SWEEP_X > 1) ? $clog2(SWEEP_X) : 1;
  localparam int W_R = (SWEEP_Y > 1) ? $clog2(SWEEP_Y) : 1;

  localparam logic [W_C-1:0] COL_LAST    = W_C'(SWEEP_X - 1);
  localparam logic [W_R-1:0] ROW_LAST    = W_R'(SWEEP_Y - 1);
  localparam logic [W_A-1:0] ROW_STEP    = W_A'(IMG_WIDTH);
  localparam logic           SINGLE_COL  = (SWEEP_X == 1);
  localparam logic           SINGLE_BEAT = (SWEEP_X == 1) && (SWEEP_Y == 1);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t         state;
  logic [W_A-1:0] base;
  logic [W_A-1:0] row_base;
  logic [W_C-1:0] col;
  logic [W_R-1:0] row;

  logic [W_A-1:0] hop_base;
  logic [W_A-1:0] row_base_nxt;
  logic [W_C-1:0] col_inc;
  logic [W_R-1:0] row_inc;

  assign hop_ready = (state == IDLE);

  // Origin address (only used on hop accept) and per-beat increments
  always_comb begin
    hop_base     = W_A'(y_hop) * ROW_STEP + W_A'(x_hop);
    row_base_nxt = row_base + ROW_STEP;
    col_inc      = col + W_C'(1);
    row_inc      = row + W_R'(1);
  end

  // Window FSM: accept an origin in IDLE, then walk the window beat by beat
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_valid <= 1'b0;
      addr       <= '0;
      row_last   <= 1'b0;
      win_last   <= 1'b0;
      col        <= '0;
      row        <= '0;
      base       <= '0;
      row_base   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hop_valid) begin
            base       <= hop_base;
            row_base   <= '0;
            col        <= '0;
            row        <= '0;
            addr       <= hop_base;
            addr_valid <= 1'b1;
            row_last   <= SINGLE_COL;
            win_last   <= SINGLE_BEAT;
            state      <= STREAM;
          end
        end
        STREAM: begin
          if (addr_ready) begin
            if (win_last) begin
              state      <= IDLE;
              addr_valid <= 1'b0;
              row_last   <= 1'b0;
              win_last   <= 1'b0;
              col        <= '0;
              row        <= '0;
            end else if (col != COL_LAST) begin
              col      <= col_inc;
              addr     <= addr + W_A'(1);
              row_last <= (col_inc == COL_LAST);
              win_last <= (col_inc == COL_LAST) && (row == ROW_LAST);
            end else begin
              // Next address is rebuilt from base plus the running row offset,
              // so no multiply is needed once the window is streaming.
              col      <= '0;
              row      <= row_inc;
              row_base <= row_base_nxt;
              addr     <= base + row_base_nxt;
              row_last <= SINGLE_COL;
              win_last <= SINGLE_COL && (row_inc == ROW_LAST);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_window_addr_gen.sv
// Self-checking bench for window_addr_gen: a reference model pushes the
// expected beat sequence when an origin is offered, and beats are popped and
// compared as the DUT transfers them.
module tb_window_addr_gen;

  localparam int IW = 41;
  localparam int IH = 50;
  localparam int SX = 24;
  localparam int SY = 24;
  localparam int WX = $clog2(IW);
  localparam int WY = $clog2(IH);
  localparam int WA = $clog2(IW*IH);

  typedef struct packed {
    logic [WA-1:0] a;
    logic          rl;
    logic          wl;
  } beat_t;

  logic          clk;
  logic          rst;
  logic          hop_valid;
  logic          hop_ready;
  logic [WX-1:0] x_hop;
  logic [WY-1:0] y_hop;
  logic          addr_valid;
  logic          addr_ready;
  logic [WA-1:0] addr;
  logic          row_last;
  logic          win_last;

  beat_t exp_q[$];
  int    tests;
  int    fails;

  window_addr_gen #(
    .IMG_WIDTH (IW),
    .IMG_HEIGHT(IH),
    .SWEEP_X   (SX),
    .SWEEP_Y   (SY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hop_valid (hop_valid),
    .hop_ready (hop_ready),
    .x_hop     (x_hop),
    .y_hop     (y_hop),
    .addr_valid(addr_valid),
    .addr_ready(addr_ready),
    .addr      (addr),
    .row_last  (row_last),
    .win_last  (win_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: full row-major window for origin (x,y)
  task automatic push_window(input int x, input int y);
    for (int r = 0; r < SY; r++) begin
      for (int c = 0; c < SX; c++) begin
        beat_t b;
        b.a  = WA'((y + r) * IW + x + c);
        b.rl = (c == SX - 1);
        b.wl = (c == SX - 1) && (r == SY - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; hop_valid = 1'b0; addr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if ({addr_valid, addr, row_last, win_last, hop_ready} !== {1'b0, WA'(0), 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_state: got valid=%b addr=%0d rl=%b wl=%b hop_ready=%b want 0 0 0 0 1",
               addr_valid, addr, row_last, win_last, hop_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (hop_ready !== 1'b1 || addr_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: got hop_ready=%b valid=%b want 1 0", hop_ready, addr_valid);
    end
  endtask

  task automatic test_full_window(input int x, input int y);
    beat_t e;
    int beats, rl_cnt, wl_cnt;
    bit done;
    @(negedge clk);
    tests++;
    if (hop_ready !== 1'b1) begin
      fails++;
      $display("FAIL win_hop_ready (%0d,%0d): got %b want 1", x, y, hop_ready);
    end
    hop_valid = 1'b1; x_hop = WX'(x); y_hop = WY'(y); addr_ready = 1'b1;
    push_window(x, y);
    beats = 0; rl_cnt = 0; wl_cnt = 0; done = 1'b0;
    for (int cyc = 0; cyc < 2*SX*SY && !done; cyc++) begin
      @(negedge clk);
      hop_valid = 1'b0;
      tests++;
      if (addr_valid !== 1'b1 || exp_q.size() == 0) begin
        fails++;
        $display("FAIL win_valid (%0d,%0d) beat %0d: got valid=%b want 1", x, y, beats, addr_valid);
        done = 1'b1;
      end else begin
        e = exp_q.pop_front();
        if (row_last === 1'b1) rl_cnt++;
        if (win_last === 1'b1) wl_cnt++;
        if ({addr, row_last, win_last} !== {e.a, e.rl, e.wl}) begin
          fails++;
          $display("FAIL win_beat (%0d,%0d) beat %0d: got addr=%0d rl=%b wl=%b want addr=%0d rl=%b wl=%b",
                   x, y, beats, addr, row_last, win_last, e.a, e.rl, e.wl);
        end
        beats++;
        if (e.wl) done = 1'b1;
      end
    end
    tests++;
    if (beats != SX*SY || rl_cnt != SY || wl_cnt != 1) begin
      fails++;
      $display("FAIL win_counts (%0d,%0d): got beats=%0d row_last=%0d win_last=%0d want %0d %0d 1",
               x, y, beats, rl_cnt, wl_cnt, SX*SY, SY);
    end
    exp_q.delete();
    @(negedge clk);
    tests++;
    if (addr_valid !== 1'b0 || hop_ready !== 1'b1) begin
      fails++;
      $display("FAIL win_end (%0d,%0d): got valid=%b hop_ready=%b want 0 1", x, y, addr_valid, hop_ready);
    end
  endtask

  task automatic test_backpressure();
    beat_t e;
    int beats, stall;
    bit done;
    @(negedge clk);
    hop_valid = 1'b1; x_hop = '0; y_hop = '0; addr_ready = 1'b1;
    push_window(0, 0);
    beats = 0; stall = 0; done = 1'b0;
    for (int cyc = 0; cyc < 8*SX*SY && !done; cyc++) begin
      @(negedge clk);
      hop_valid = 1'b0;
      tests++;
      if (addr_valid !== 1'b1 || exp_q.size() == 0) begin
        fails++;
        $display("FAIL bp_valid beat %0d cyc %0d: got valid=%b want 1", beats, cyc, addr_valid);
        done = 1'b1;
      end else begin
        if (beats == 5 && stall < 3) begin
          addr_ready = 1'b0;
          stall++;
        end else if (beats > 5) begin
          addr_ready = ($urandom_range(0, 3) != 0);
        end else begin
          addr_ready = 1'b1;
        end
        e = exp_q[0];
        if ({addr, row_last, win_last} !== {e.a, e.rl, e.wl}) begin
          fails++;
          $display("FAIL bp_beat beat %0d ready=%b: got addr=%0d rl=%b wl=%b want addr=%0d rl=%b wl=%b",
                   beats, addr_ready, addr, row_last, win_last, e.a, e.rl, e.wl);
        end
        if (addr_ready) begin
          void'(exp_q.pop_front());
          beats++;
          if (e.wl) done = 1'b1;
        end
      end
    end
    tests++;
    if (beats != SX*SY || stall != 3) begin
      fails++;
      $display("FAIL bp_counts: got beats=%0d stalls=%0d want %0d 3", beats, stall, SX*SY);
    end
    exp_q.delete();
    addr_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (addr_valid !== 1'b0 || hop_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_end: got valid=%b hop_ready=%b want 0 1", addr_valid, hop_ready);
    end
  endtask

  task automatic test_hop_ignored();
    beat_t e;
    bit done;
    @(negedge clk);
    hop_valid = 1'b1; x_hop = WX'(3); y_hop = WY'(2); addr_ready = 1'b1;
    push_window(3, 2);
    done = 1'b0;
    for (int cyc = 0; cyc < 2*SX*SY && !done; cyc++) begin
      @(negedge clk);
      x_hop = WX'($urandom_range(0, IW - 1));
      y_hop = WY'($urandom_range(0, IH - 1));
      tests++;
      if (addr_valid !== 1'b1 || hop_ready !== 1'b0 || exp_q.size() == 0) begin
        fails++;
        $display("FAIL ign_stream cyc %0d: got valid=%b hop_ready=%b want 1 0", cyc, addr_valid, hop_ready);
        done = 1'b1;
      end else begin
        e = exp_q.pop_front();
        if ({addr, row_last, win_last} !== {e.a, e.rl, e.wl}) begin
          fails++;
          $display("FAIL ign_beat cyc %0d: got addr=%0d rl=%b wl=%b want addr=%0d rl=%b wl=%b",
                   cyc, addr, row_last, win_last, e.a, e.rl, e.wl);
        end
        if (e.wl) begin
          done = 1'b1;
          x_hop = WX'(5); y_hop = WY'(7);
        end
      end
    end
    exp_q.delete();
    push_window(5, 7);
    @(negedge clk);
    tests++;
    if (hop_ready !== 1'b1 || addr_valid !== 1'b0) begin
      fails++;
      $display("FAIL ign_idle: got hop_ready=%b valid=%b want 1 0", hop_ready, addr_valid);
    end
    @(negedge clk);
    hop_valid = 1'b0;
    e = exp_q.pop_front();
    tests++;
    if (addr_valid !== 1'b1 || addr !== e.a) begin
      fails++;
      $display("FAIL ign_next_hop: got valid=%b addr=%0d want 1 %0d", addr_valid, addr, e.a);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset_abort();
    beat_t e;
    int beats;
    bit done;
    @(negedge clk);
    hop_valid = 1'b1; x_hop = '0; y_hop = '0; addr_ready = 1'b1;
    push_window(0, 0);
    beats = 0; done = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(negedge clk);
      hop_valid = 1'b0;
      tests++;
      if (addr_valid !== 1'b1 || exp_q.size() == 0) begin
        fails++;
        $display("FAIL abort_valid beat %0d: got valid=%b want 1", beats, addr_valid);
        done = 1'b1;
      end else begin
        e = exp_q.pop_front();
        if ({addr, row_last, win_last} !== {e.a, e.rl, e.wl}) begin
          fails++;
          $display("FAIL abort_beat beat %0d: got addr=%0d want %0d", beats, addr, e.a);
        end
        if (beats == 100) begin
          rst = 1'b1;
          done = 1'b1;
        end
        beats++;
      end
    end
    exp_q.delete();
    @(negedge clk);
    tests++;
    if ({addr_valid, addr, row_last, win_last, hop_ready} !== {1'b0, WA'(0), 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL abort_reset: got valid=%b addr=%0d rl=%b wl=%b hop_ready=%b want 0 0 0 0 1",
               addr_valid, addr, row_last, win_last, hop_ready);
    end
    rst = 1'b0;
    hop_valid = 1'b1; x_hop = WX'(1); y_hop = WY'(1);
    push_window(1, 1);
    beats = 0; done = 1'b0;
    for (int cyc = 0; cyc < 2*SX*SY && !done; cyc++) begin
      @(negedge clk);
      hop_valid = 1'b0;
      tests++;
      if (addr_valid !== 1'b1 || exp_q.size() == 0) begin
        fails++;
        $display("FAIL abort_new_valid beat %0d: got valid=%b want 1", beats, addr_valid);
        done = 1'b1;
      end else begin
        e = exp_q.pop_front();
        if ({addr, row_last, win_last} !== {e.a, e.rl, e.wl}) begin
          fails++;
          $display("FAIL abort_new_beat beat %0d: got addr=%0d rl=%b wl=%b want addr=%0d rl=%b wl=%b",
                   beats, addr, row_last, win_last, e.a, e.rl, e.wl);
        end
        beats++;
        if (e.wl) done = 1'b1;
      end
    end
    tests++;
    if (beats != SX*SY) begin
      fails++;
      $display("FAIL abort_new_count: got %0d beats want %0d", beats, SX*SY);
    end
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    beat_t e;
    int wins, gap;
    @(negedge clk);
    hop_valid = 1'b1; x_hop = '0; y_hop = '0; addr_ready = 1'b1;
    push_window(0, 0);
    push_window(2, 3);
    wins = 0; gap = -1;
    for (int cyc = 0; cyc < 4*SX*SY && wins < 2; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        x_hop = WX'(2); y_hop = WY'(3);
      end
      if (addr_valid === 1'b1) begin
        if (gap >= 0) begin
          tests++;
          if (gap != 1) begin
            fails++;
            $display("FAIL b2b_gap: got %0d idle cycles want 1", gap);
          end
          gap = -1;
        end
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL b2b_extra_beat: got addr=%0d want no beat", addr);
        end else begin
          e = exp_q.pop_front();
          if ({addr, row_last, win_last} !== {e.a, e.rl, e.wl}) begin
            fails++;
            $display("FAIL b2b_beat win %0d: got addr=%0d rl=%b wl=%b want addr=%0d rl=%b wl=%b",
                     wins, addr, row_last, win_last, e.a, e.rl, e.wl);
          end
          if (e.wl) begin
            wins++;
            gap = 0;
            if (wins == 2) hop_valid = 1'b0;
          end
        end
      end else if (gap >= 0) begin
        gap++;
      end else begin
        tests++;
        fails++;
        $display("FAIL b2b_idle cyc %0d: got valid=0 want 1", cyc);
      end
    end
    hop_valid = 1'b0;
    tests++;
    if (wins != 2 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL b2b_windows: got %0d windows, %0d beats left want 2 0", wins, exp_q.size());
    end
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (addr_valid !== 1'b0 || hop_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_end: got valid=%b hop_ready=%b want 0 1", addr_valid, hop_ready);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    hop_valid = 1'b0;
    x_hop = '0;
    y_hop = '0;
    addr_ready = 1'b0;
    test_reset();
    test_full_window(0, 0);
    test_full_window(16, 25);
    test_backpressure();
    test_hop_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/window_addr_gen.md
WINDOW_ADDR_GEN -- requirements
Module: window_addr_gen

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 41: integral image width in pixels.
REQ-002 SHALL have parameter IMG_HEIGHT, default 50: integral image height in pixels.
REQ-003 SHALL have parameter SWEEP_X, default 24: window width in pixels.
REQ-004 SHALL have parameter SWEEP_Y, default 24: window height in pixels.
REQ-005 SHALL derive localparams W_X = $clog2(IMG_WIDTH), W_Y = $clog2(IMG_HEIGHT), W_A = $clog2(IMG_WIDTH*IMG_HEIGHT) (12 at defaults).
REQ-006 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port hop_valid  input  1  upstream window origin valid.
REQ-009 SHALL have port hop_ready  output  1  block can accept a window origin.
REQ-010 SHALL have port x_hop  input  W_X  window origin column.
REQ-011 SHALL have port y_hop  input  W_Y  window origin row.
REQ-012 SHALL have port addr_valid  output  1  addr beat valid.
REQ-013 SHALL have port addr_ready  input  1  downstream memory reader accepts beat.
REQ-014 SHALL have port addr  output  W_A  linear pixel address in integral image memory.
REQ-015 SHALL have port row_last  output  1  beat is last column of a window row.
REQ-016 SHALL have port win_last  output  1  beat is final beat of the window.

Function
REQ-017 SHALL implement FSM with states IDLE and STREAM only.
REQ-018 SHALL drive hop_ready = 1 iff state is IDLE (decoded from state register, no dependence on hop_valid).
REQ-019 SHALL accept a hop when hop_valid && hop_ready at a rising edge T; latch base = y_hop*IMG_WIDTH + x_hop, col = 0, row = 0; enter STREAM.
REQ-020 SHALL assert addr_valid from cycle T+1 (one-cycle accept-to-first-beat latency) and keep it asserted throughout STREAM.
REQ-021 SHALL present addr = base + row*IMG_WIDTH + col, from registers only (no combinational path from any input to addr, row_last, win_last, addr_valid).
REQ-022 SHALL compute the row term incrementally (row-base register += IMG_WIDTH per row); no multiplier on the per-beat path.
REQ-023 SHALL transfer a beat only when addr_valid && addr_ready; with addr_ready low, addr, row_last, win_last SHALL hold stable.
REQ-024 SHALL on transfer with col < SWEEP_X-1: col += 1.
REQ-025 SHALL on transfer with col == SWEEP_X-1 and row < SWEEP_Y-1: col = 0, row += 1, row-base += IMG_WIDTH.
REQ-026 SHALL assert row_last iff col == SWEEP_X-1; win_last iff additionally row == SWEEP_Y-1.
REQ-027 SHALL on transfer of the win_last beat return to IDLE; addr_valid = 0 and hop_ready = 1 the following cycle.
REQ-028 SHALL emit exactly SWEEP_X*SWEEP_Y beats per accepted hop (576 at defaults), in row-major order.
REQ-029 SHALL ignore hop_valid, x_hop, y_hop while in STREAM; hops are never overlapped or queued.
REQ-030 SHALL treat origins with x_hop > IMG_WIDTH-SWEEP_X or y_hop > IMG_HEIGHT-SWEEP_Y as out of contract; addresses are then truncated to W_A bits, no error reporting.

Reset
REQ-031 SHALL on rst: state = IDLE, addr_valid = 0, addr = 0, row_last = 0, win_last = 0, row = col = 0, base = 0; hop_ready = 1 on the first cycle after reset.
REQ-032 SHALL abort an in-progress window on rst without emitting further beats; the next window begins from a fresh hop.
REQ-033 SHALL give rst priority over every handshake in the same cycle.

Verification
REQ-034 SHALL cover: hop (0,0), addr_ready=1 -> 576 beats; addr 0..23, 41..64, ..., last 966; row_last on 24 beats, win_last on beat 576 only.
REQ-035 SHALL cover: hop (16,25) -> first addr 1041, first row_last addr 1064, final addr 2007 with win_last, then hop_ready=1 the next cycle.
REQ-036 SHALL cover: addr_ready low for 3 cycles mid-row (beat addr 5) -> addr stays 5, addr_valid stays 1, next accepted beat is 6, no beat lost or duplicated.
REQ-037 SHALL cover: hop_valid held high with changing x_hop/y_hop during STREAM -> hop_ready=0, addresses unaffected; the next hop is taken only after win_last transfers.
REQ-038 SHALL cover: rst asserted at beat 100 -> addr_valid=0 next cycle, hop_ready=1; new hop (1,1) -> first addr 42.
REQ-039 SHALL cover: back-to-back hops from a free-running upstream (hop_valid always 1) -> exactly one idle cycle between win_last transfer and the next window's first beat.
